// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller: FSM states, redirect causes
// and the PC alignment helper used on every redirect target.
package fetch_redirect_ctrl_pkg;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        WRITE = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3,
        FLUSH = 3'd4,
        HALT  = 3'd5
    } FetchCtrlState;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        TRAP    = 3'd1,
        MISPRED = 3'd2,
        FENCEI  = 3'd3,
        DECODE  = 3'd4,
        RESUME  = 3'd5
    } RedirectCause;

    // Fetch addresses are at least halfword aligned; bit 0 is never a real address bit.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Redirect sources, stall inputs, icache flush handshake and PC-block drive.
// Flush handshake: OUT_icFlushReq is held high until IN_icFlushAck is sampled high on a rising clk edge.
interface fetch_redirect_ctrl_if;
    logic        IN_trapValid;
    logic [31:0] IN_trapPc;
    logic        IN_mispredValid;
    logic [31:0] IN_mispredPc;
    logic        IN_fenceiValid;
    logic [31:0] IN_fenceiPc;
    logic        IN_decRedirValid;
    logic [31:0] IN_decRedirPc;
    logic        OUT_icFlushReq;
    logic        IN_icFlushAck;
    logic        IN_icReady;
    logic        IN_ibufFull;
    logic        IN_haltReq;
    logic        IN_resumeValid;
    logic [31:0] IN_resumePc;
    logic [31:0] OUT_pc;
    logic        OUT_write;
    logic        OUT_en0;
    logic        OUT_en1;
    logic        OUT_halted;

    modport master (
        output IN_trapValid, IN_trapPc, IN_mispredValid, IN_mispredPc,
        output IN_fenceiValid, IN_fenceiPc, IN_decRedirValid, IN_decRedirPc,
        output IN_icFlushAck, IN_icReady, IN_ibufFull,
        output IN_haltReq, IN_resumeValid, IN_resumePc,
        input  OUT_icFlushReq, OUT_pc, OUT_write, OUT_en0, OUT_en1, OUT_halted
    );

    modport slave (
        input  IN_trapValid, IN_trapPc, IN_mispredValid, IN_mispredPc,
        input  IN_fenceiValid, IN_fenceiPc, IN_decRedirValid, IN_decRedirPc,
        input  IN_icFlushAck, IN_icReady, IN_ibufFull,
        input  IN_haltReq, IN_resumeValid, IN_resumePc,
        output OUT_icFlushReq, OUT_pc, OUT_write, OUT_en0, OUT_en1, OUT_halted
    );
endinterface

// File: rtl/fetch_redirect_ctrl_redirect_select.sv
// Fixed-priority redirect arbiter: trap > mispred > fencei > decode.
// While a flush is running only trap and mispredict may replace the pending target.
module redirect_select
    import fetch_redirect_ctrl_pkg::*;
(
    input  logic         trap_valid,
    input  logic [31:0]  trap_pc,
    input  logic         mispred_valid,
    input  logic [31:0]  mispred_pc,
    input  logic         fencei_valid,
    input  logic [31:0]  fencei_pc,
    input  logic         dec_valid,
    input  logic [31:0]  dec_pc,
    input  logic         flush_active,
    output RedirectCause cause,
    output logic [31:0]  target
);

    always_comb begin
        cause  = NONE;
        target = '0;
        if (trap_valid) begin
            cause  = TRAP;
            target = align_pc(trap_pc);
        end else if (mispred_valid) begin
            cause  = MISPRED;
            target = align_pc(mispred_pc);
        end else if (fencei_valid && !flush_active) begin
            cause  = FENCEI;
            target = align_pc(fencei_pc);
        end else if (dec_valid && !flush_active) begin
            cause  = DECODE;
            target = align_pc(dec_pc);
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates redirects, sequences PC writes, drains
// stale pcLast, runs the icache flush for fence.i and handles debug halt/resume.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
)
(
    input  logic                   clk,
    input  logic                   rst,
    fetch_redirect_ctrl_if.slave   bus,
    output FetchCtrlState          state_dbg
);

    FetchCtrlState state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    RedirectCause  cause;
    logic [31:0]   target;
    logic          stall;

    assign stall = ~bus.IN_icReady | bus.IN_ibufFull;

    redirect_select u_redirect_select (
        .trap_valid    (bus.IN_trapValid),
        .trap_pc       (bus.IN_trapPc),
        .mispred_valid (bus.IN_mispredValid),
        .mispred_pc    (bus.IN_mispredPc),
        .fencei_valid  (bus.IN_fenceiValid),
        .fencei_pc     (bus.IN_fenceiPc),
        .dec_valid     (bus.IN_decRedirValid),
        .dec_pc        (bus.IN_decRedirPc),
        .flush_active  (state_q == FLUSH),
        .cause         (cause),
        .target        (target)
    );

    // pc_q doubles as the pending target while a flush is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        bus.OUT_write      = 1'b0;
        bus.OUT_en0        = 1'b0;
        bus.OUT_en1        = 1'b0;
        bus.OUT_icFlushReq = 1'b0;
        bus.OUT_halted     = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = WRITE;
                pc_d    = RESET_VEC;
            end
            WRITE: begin
                bus.OUT_write = 1'b1;
                if (cause != NONE) begin
                    pc_d = target;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // en1 stays low so the stale pcLast is never forwarded.
                bus.OUT_en0 = !stall;
                if (cause != NONE) begin
                    state_d = (cause == FENCEI) ? FLUSH : WRITE;
                    pc_d    = target;
                end else if (!stall) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.OUT_en0 = !stall;
                bus.OUT_en1 = !stall;
                if (cause != NONE) begin
                    state_d = (cause == FENCEI) ? FLUSH : WRITE;
                    pc_d    = target;
                end else if (bus.IN_haltReq) begin
                    state_d = HALT;
                end
            end
            FLUSH: begin
                bus.OUT_icFlushReq = 1'b1;
                if (cause != NONE) begin
                    pc_d = target;
                end
                if (bus.IN_icFlushAck) begin
                    state_d = WRITE;
                end
            end
            HALT: begin
                bus.OUT_halted = 1'b1;
                if (bus.IN_resumeValid) begin
                    state_d = WRITE;
                    pc_d    = align_pc(bus.IN_resumePc);
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.OUT_pc = pc_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: each task drives one scenario and
// checks outputs #1 after the rising edge against hand-computed values.
module tb_fetch_redirect_ctrl;
    import fetch_redirect_ctrl_pkg::*;

    localparam logic [31:0] RV = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    int            checks = 0;
    int            errors = 0;
    FetchCtrlState state_dbg;
    logic [4:0]    flags;

    fetch_redirect_ctrl_if bus ();

    fetch_redirect_ctrl #(.RESET_VEC(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // {write, en0, en1, icFlushReq, halted}
    assign flags = {bus.OUT_write, bus.OUT_en0, bus.OUT_en1, bus.OUT_icFlushReq, bus.OUT_halted};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.IN_trapValid     = 1'b0;
        bus.IN_trapPc        = '0;
        bus.IN_mispredValid  = 1'b0;
        bus.IN_mispredPc     = '0;
        bus.IN_fenceiValid   = 1'b0;
        bus.IN_fenceiPc      = '0;
        bus.IN_decRedirValid = 1'b0;
        bus.IN_decRedirPc    = '0;
        bus.IN_icFlushAck    = 1'b0;
        bus.IN_icReady       = 1'b1;
        bus.IN_ibufFull      = 1'b0;
        bus.IN_haltReq       = 1'b0;
        bus.IN_resumeValid   = 1'b0;
        bus.IN_resumePc      = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (flags !== 5'b00000 || bus.OUT_pc !== RV || state_dbg !== BOOT) begin errors++; $display("FAIL reset_hold: flags=%b pc=%h state=%0d, expected 00000 %h %0d", flags, bus.OUT_pc, state_dbg, RV, BOOT); end
        rst = 1'b0;
        bus.IN_trapValid = 1'b1;
        bus.IN_trapPc    = 32'h0000_0900;
        tick();
        clear_inputs();
        checks++; if (flags !== 5'b10000 || bus.OUT_pc !== RV || state_dbg !== WRITE) begin errors++; $display("FAIL boot_write: flags=%b pc=%h state=%0d, expected 10000 %h %0d", flags, bus.OUT_pc, state_dbg, RV, WRITE); end
        tick();
        checks++; if (flags !== 5'b01000 || state_dbg !== DRAIN) begin errors++; $display("FAIL boot_drain: flags=%b state=%0d, expected 01000 %0d", flags, state_dbg, DRAIN); end
        tick();
        checks++; if (flags !== 5'b01100 || state_dbg !== RUN) begin errors++; $display("FAIL boot_run: flags=%b state=%0d, expected 01100 %0d", flags, state_dbg, RUN); end
    endtask

    task automatic test_priority();
        bus.IN_trapValid     = 1'b1; bus.IN_trapPc     = 32'h0000_0100;
        bus.IN_mispredValid  = 1'b1; bus.IN_mispredPc  = 32'h0000_0200;
        bus.IN_decRedirValid = 1'b1; bus.IN_decRedirPc = 32'h0000_0300;
        tick();
        clear_inputs();
        checks++; if (flags !== 5'b10000 || bus.OUT_pc !== 32'h0000_0100) begin errors++; $display("FAIL prio_write: flags=%b pc=%h, expected 10000 00000100", flags, bus.OUT_pc); end
        tick();
        checks++; if (flags !== 5'b01000 || state_dbg !== DRAIN) begin errors++; $display("FAIL prio_single_write: flags=%b state=%0d, expected 01000 %0d", flags, state_dbg, DRAIN); end
        tick();
        checks++; if (state_dbg !== RUN) begin errors++; $display("FAIL prio_run: state=%0d, expected %0d", state_dbg, RUN); end
    endtask

    task automatic test_write_extend();
        bus.IN_decRedirValid = 1'b1; bus.IN_decRedirPc = 32'h0000_0301;
        tick();
        clear_inputs();
        checks++; if (flags !== 5'b10000 || bus.OUT_pc !== 32'h0000_0300) begin errors++; $display("FAIL dec_align: flags=%b pc=%h, expected 10000 00000300", flags, bus.OUT_pc); end
        bus.IN_mispredValid = 1'b1; bus.IN_mispredPc = 32'h0000_0355;
        tick();
        clear_inputs();
        checks++; if (flags !== 5'b10000 || bus.OUT_pc !== 32'h0000_0354 || state_dbg !== WRITE) begin errors++; $display("FAIL write_extend: flags=%b pc=%h state=%0d, expected 10000 00000354 %0d", flags, bus.OUT_pc, state_dbg, WRITE); end
        tick();
        bus.IN_icReady = 1'b0;
        #1;
        checks++; if (flags !== 5'b00000 || state_dbg !== DRAIN) begin errors++; $display("FAIL drain_stall: flags=%b state=%0d, expected 00000 %0d", flags, state_dbg, DRAIN); end
        tick();
        checks++; if (state_dbg !== DRAIN) begin errors++; $display("FAIL drain_hold: state=%0d, expected %0d", state_dbg, DRAIN); end
        bus.IN_icReady = 1'b1;
        #1;
        checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL drain_en: flags=%b, expected 01000", flags); end
        tick();
        checks++; if (flags !== 5'b01100 || state_dbg !== RUN) begin errors++; $display("FAIL drain_exit: flags=%b state=%0d, expected 01100 %0d", flags, state_dbg, RUN); end
    endtask

    task automatic test_fencei();
        int high_cycles = 0;
        bus.IN_fenceiValid = 1'b1; bus.IN_fenceiPc = 32'h0000_0400;
        tick();
        clear_inputs();
        for (int i = 1; i <= 5; i++) begin
            if (flags === 5'b00010) high_cycles++;
            bus.IN_icFlushAck = (i == 5);
            tick();
        end
        clear_inputs();
        checks++; if (high_cycles !== 5) begin errors++; $display("FAIL flush_len: flush cycles=%0d, expected 5", high_cycles); end
        checks++; if (flags !== 5'b10000 || bus.OUT_pc !== 32'h0000_0400) begin errors++; $display("FAIL flush_write: flags=%b pc=%h, expected 10000 00000400", flags, bus.OUT_pc); end
        repeat (2) tick();
        checks++; if (state_dbg !== RUN) begin errors++; $display("FAIL flush_run: state=%0d, expected %0d", state_dbg, RUN); end
    endtask

    task automatic test_fencei_replace();
        bus.IN_fenceiValid = 1'b1; bus.IN_fenceiPc = 32'h0000_0400;
        tick();
        clear_inputs();
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin
                bus.IN_mispredValid = 1'b1; bus.IN_mispredPc = 32'h0000_0500;
            end
            if (i == 3) begin
                bus.IN_decRedirValid = 1'b1; bus.IN_decRedirPc = 32'h0000_0600;
                bus.IN_fenceiValid   = 1'b1; bus.IN_fenceiPc   = 32'h0000_0700;
            end
            bus.IN_icFlushAck = (i == 5);
            tick();
            clear_inputs();
            if (i < 5) begin
                checks++; if (flags !== 5'b00010) begin errors++; $display("FAIL flush_noabort_%0d: flags=%b, expected 00010", i, flags); end
            end
        end
        checks++; if (flags !== 5'b10000 || bus.OUT_pc !== 32'h0000_0500) begin errors++; $display("FAIL flush_replace: flags=%b pc=%h, expected 10000 00000500", flags, bus.OUT_pc); end
        repeat (2) tick();
    endtask

    task automatic test_stall();
        bus.IN_ibufFull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (flags !== 5'b00000 || state_dbg !== RUN) begin errors++; $display("FAIL ibuf_stall_%0d: flags=%b state=%0d, expected 00000 %0d", i, flags, state_dbg, RUN); end
            tick();
        end
        bus.IN_ibufFull = 1'b0;
        #1;
        checks++; if (flags !== 5'b01100) begin errors++; $display("FAIL ibuf_release: flags=%b, expected 01100", flags); end
        bus.IN_icReady = 1'b0;
        #1;
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL icready_stall: flags=%b, expected 00000", flags); end
        bus.IN_icReady = 1'b1;
        tick();
    endtask

    task automatic test_halt();
        bus.IN_haltReq = 1'b1;
        tick();
        clear_inputs();
        checks++; if (flags !== 5'b00001 || state_dbg !== HALT) begin errors++; $display("FAIL halt_enter: flags=%b state=%0d, expected 00001 %0d", flags, state_dbg, HALT); end
        bus.IN_trapValid = 1'b1; bus.IN_trapPc = 32'h0000_0700;
        tick();
        clear_inputs();
        checks++; if (flags !== 5'b00001 || state_dbg !== HALT) begin errors++; $display("FAIL halt_ignore_trap: flags=%b state=%0d, expected 00001 %0d", flags, state_dbg, HALT); end
        bus.IN_resumeValid = 1'b1; bus.IN_resumePc = 32'h0000_0800;
        tick();
        clear_inputs();
        checks++; if (flags !== 5'b10000 || bus.OUT_pc !== 32'h0000_0800) begin errors++; $display("FAIL resume_write: flags=%b pc=%h, expected 10000 00000800", flags, bus.OUT_pc); end
        tick();
        checks++; if (flags !== 5'b01000 || state_dbg !== DRAIN) begin errors++; $display("FAIL resume_drain: flags=%b state=%0d, expected 01000 %0d", flags, state_dbg, DRAIN); end
        tick();
    endtask

    task automatic test_halt_deferred();
        bus.IN_haltReq   = 1'b1;
        bus.IN_trapValid = 1'b1; bus.IN_trapPc = 32'h0000_0900;
        tick();
        bus.IN_trapValid = 1'b0;
        checks++; if (state_dbg !== WRITE || bus.OUT_pc !== 32'h0000_0900) begin errors++; $display("FAIL defer_write: state=%0d pc=%h, expected %0d 00000900", state_dbg, bus.OUT_pc, WRITE); end
        tick();
        checks++; if (state_dbg !== DRAIN || bus.OUT_halted !== 1'b0) begin errors++; $display("FAIL defer_drain: state=%0d halted=%b, expected %0d 0", state_dbg, bus.OUT_halted, DRAIN); end
        tick();
        checks++; if (state_dbg !== RUN) begin errors++; $display("FAIL defer_run: state=%0d, expected %0d", state_dbg, RUN); end
        tick();
        clear_inputs();
        checks++; if (state_dbg !== HALT || flags !== 5'b00001) begin errors++; $display("FAIL defer_halt: state=%0d flags=%b, expected %0d 00001", state_dbg, flags, HALT); end
        bus.IN_resumeValid = 1'b1; bus.IN_resumePc = 32'h0000_0A01;
        tick();
        clear_inputs();
        checks++; if (flags !== 5'b10000 || bus.OUT_pc !== 32'h0000_0A00) begin errors++; $display("FAIL resume_align: flags=%b pc=%h, expected 10000 00000a00", flags, bus.OUT_pc); end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_flush();
        bus.IN_fenceiValid = 1'b1; bus.IN_fenceiPc = 32'h0000_0B00;
        tick();
        clear_inputs();
        checks++; if (flags !== 5'b00010 || state_dbg !== FLUSH) begin errors++; $display("FAIL rflush_enter: flags=%b state=%0d, expected 00010 %0d", flags, state_dbg, FLUSH); end
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (flags !== 5'b00000 || bus.OUT_pc !== RV || state_dbg !== BOOT) begin errors++; $display("FAIL rflush_async: flags=%b pc=%h state=%0d, expected 00000 %h %0d", flags, bus.OUT_pc, state_dbg, RV, BOOT); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (flags !== 5'b10000 || bus.OUT_pc !== RV) begin errors++; $display("FAIL rflush_reboot: flags=%b pc=%h, expected 10000 %h", flags, bus.OUT_pc, RV); end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_write_extend();
        test_fencei();
        test_fencei_replace();
        test_stall();
        test_halt();
        test_halt_deferred();
        test_reset_mid_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameter: RESET_VEC, default 32'h0000_0000, PC loaded after reset.
REQ-002 Port: clk  in  1  clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Ports: IN_trapValid  in  1, and IN_trapPc  in  32: trap/interrupt redirect.
REQ-005 Ports: IN_mispredValid  in  1, and IN_mispredPc  in  32: branch mispredict redirect from execute.
REQ-006 Ports: IN_fenceiValid  in  1, and IN_fenceiPc  in  32: fence.i, meaning icache flush then redirect.
REQ-007 Ports: IN_decRedirValid  in  1, and IN_decRedirPc  in  32: decode-stage jump redirect.
REQ-008 Ports: OUT_icFlushReq  out  1, and IN_icFlushAck  in  1: icache flush handshake.
REQ-009 Ports: IN_icReady  in  1, and IN_ibufFull  in  1: fetch stall sources.
REQ-010 Ports: IN_haltReq  in  1, IN_resumeValid  in  1, and IN_resumePc  in  32: debug halt and resume.
REQ-011 Ports: OUT_pc  out  32, OUT_write  out  1, OUT_en0  out  1, OUT_en1  out  1: drive the PC block's IN_pc, IN_write, en0 and en1.
REQ-012 Port: OUT_halted  out  1  fetch halted.

Function
REQ-013 States SHALL be: BOOT, WRITE, DRAIN, RUN, FLUSH, HALT.
REQ-014 Redirect priority SHALL be trap > mispred > fencei > decRedir; lower-priority requests in the same cycle are dropped, not queued.
REQ-015 An accepted redirect in cycle t SHALL give OUT_write=1 and OUT_pc=target in cycle t+1, for exactly one cycle (state WRITE).
REQ-016 In WRITE, OUT_en0 and OUT_en1 SHALL both be 0.
REQ-017 DRAIN SHALL last one non-stalled cycle with OUT_en0=1 and OUT_en1=0, so stale pcLast is never forwarded.
REQ-018 In RUN, OUT_en0 and OUT_en1 SHALL both equal !(~IN_icReady | IN_ibufFull).
REQ-019 A redirect accepted in DRAIN or RUN SHALL go to WRITE; a redirect in WRITE SHALL overwrite the target and extend WRITE by one cycle.
REQ-020 A fencei accepted in RUN or DRAIN SHALL enter FLUSH.
REQ-021 In FLUSH: OUT_icFlushReq=1 and en0=en1=0 until IN_icFlushAck is sampled high.
REQ-022 On leaving FLUSH, the block SHALL go to WRITE with the pending target.
REQ-023 A trap or mispredict arriving during FLUSH SHALL replace the pending target by priority; the flush SHALL NOT abort.
REQ-024 IN_haltReq sampled in RUN with no redirect SHALL enter HALT: en0=en1=0, OUT_halted=1.
REQ-025 In HALT, only IN_resumeValid SHALL act: it goes to WRITE with IN_resumePc and clears OUT_halted; all other redirects are ignored.
REQ-026 IN_haltReq SHALL be deferred while in WRITE, DRAIN or FLUSH.
REQ-027 The block SHALL force OUT_pc[0]=0 on every redirect target.

Reset
REQ-028 While rst is high: state=BOOT, OUT_pc=RESET_VEC, OUT_write=0, OUT_en0=0, OUT_en1=0, OUT_icFlushReq=0, OUT_halted=0, pending target=RESET_VEC.
REQ-029 The first cycle after rst deassertion SHALL move BOOT to WRITE with OUT_pc=RESET_VEC.
REQ-030 Any redirect seen in the BOOT cycle SHALL be ignored.
REQ-031 Reset asserted mid-FLUSH SHALL drop OUT_icFlushReq immediately (asynchronously).

Structure
REQ-032 The shared package SHALL hold the FetchCtrlState enum and the RedirectCause enum (NONE, TRAP, MISPRED, FENCEI, DECODE, RESUME).
REQ-033 One combinational sub-module, redirect_select, SHALL do the priority selection and output cause and target.

Verification
REQ-034 Release reset -> cycle 1: OUT_write=1 with OUT_pc=RESET_VEC; cycle 2: en0=1, en1=0; cycle 3 with icReady=1: en0=en1=1.
REQ-035 Same cycle trapPc=0x100, mispredPc=0x200, decRedirPc=0x300 -> one OUT_write, with OUT_pc=0x100.
REQ-036 fenceiPc=0x400, ack after 5 cycles -> OUT_icFlushReq high for 5 cycles, then OUT_write with 0x400; inject mispred 0x500 in flush cycle 2 -> target 0x500 instead.
REQ-037 IN_ibufFull=1 for 3 cycles in RUN -> en0=en1=0 for those 3 cycles; no OUT_write.
REQ-038 haltReq in RUN -> OUT_halted=1 next cycle and trap ignored; resume with 0x800 -> OUT_write with 0x800, then DRAIN.
